// File: rtl/snes_pkg.sv
// Shared definitions for the SNES multi-source controller encoder:
// FSM state encoding, source-mode codes, wire idle level and a sizing helper.
package snes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2
  } snes_state_t;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_MERGE = 2'd1;
  localparam logic [1:0] MODE_FIRST = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  // Level on snes_out when idle, padding, or no button pressed (active-low data).
  localparam logic SNES_IDLE_LVL = 1'b1;

  // Width of a channel index; never below one bit so a 1-channel build still has a port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snes_multi_encoder_if.sv
// Console-facing bundle of the encoder: the console drives clock/latch,
// the encoder returns serial data plus frame status.
interface snes_multi_encoder_if;
  logic        snes_clk;
  logic        snes_latch;
  logic        snes_out;
  logic        busy;
  logic [15:0] frame_cnt;

  modport master (
    output snes_clk,
    output snes_latch,
    input  snes_out,
    input  busy,
    input  frame_cnt
  );

  modport slave (
    input  snes_clk,
    input  snes_latch,
    output snes_out,
    output busy,
    output frame_cnt
  );
endinterface

// File: rtl/snes_src_select.sv
// Combinational source selection across the controller channels:
// FIXED picks channel sel (out of range -> zeros), MERGE ORs every channel,
// FIRST_ACTIVE takes the lowest-index channel with any bit set.
// The reserved mode code behaves as FIXED.
module snes_src_select
  import snes_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int BTN_W  = 8,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic [NUM_CH*BTN_W-1:0] ch_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              mode,
  output logic [BTN_W-1:0]        src
);

  logic [BTN_W-1:0] fixed_v;
  logic [BTN_W-1:0] merge_v;
  logic [BTN_W-1:0] first_v;

  // Build all three candidate vectors, then pick by mode.
  always_comb begin
    fixed_v = '0;
    merge_v = '0;
    first_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) fixed_v = ch_data[i*BTN_W +: BTN_W];
      merge_v = merge_v | ch_data[i*BTN_W +: BTN_W];
    end
    // Walk downward so the lowest active channel is the last to win.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (|ch_data[i*BTN_W +: BTN_W]) first_v = ch_data[i*BTN_W +: BTN_W];
    end
    case (mode)
      MODE_MERGE: src = merge_v;
      MODE_FIRST: src = first_v;
      default:    src = fixed_v;
    endcase
  end

endmodule

// File: rtl/snes_multi_encoder.sv
// SNES controller encoder fed by several button sources. Synchronises the
// console latch/clock into the clk domain, captures the selected source on
// latch, and shifts it out active-low one bit per console clock.
// Optional feature: define SNES_TURBO_EN to add turbo_mask, which reports
// masked pressed buttons only on frames with an even frame_cnt.
module snes_multi_encoder
  import snes_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int BTN_W       = 8,
  parameter int FRAME_W     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096,
  localparam int SEL_W      = sel_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef SNES_TURBO_EN
  input  logic [BTN_W-1:0]        turbo_mask,
`endif
  input  logic [NUM_CH*BTN_W-1:0] ch_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              mode,
  snes_multi_encoder_if.slave     bus
);

  localparam int IDX_W = $clog2(FRAME_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] latch_sync;
  logic                   clk_q;
  logic                   latch_q;
  logic                   clk_rise;
  logic                   latch_rise;
  logic                   latch_fall;

  snes_state_t            state;
  logic [FRAME_W-1:0]     shreg;
  logic [FRAME_W-1:0]     sh_next;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_next;
  logic [TMO_W-1:0]       tmo;
  logic                   snes_out_q;
  logic                   busy_q;
  logic [15:0]            frame_cnt_q;

  logic [BTN_W-1:0]       src;
  logic [BTN_W-1:0]       src_eff;
  logic [FRAME_W-1:0]     cap_vec;

  snes_src_select #(
    .NUM_CH (NUM_CH),
    .BTN_W  (BTN_W),
    .SEL_W  (SEL_W)
  ) u_src (
    .ch_data (ch_data),
    .sel     (sel),
    .mode    (mode),
    .src     (src)
  );

`ifdef SNES_TURBO_EN
  // Turbo buttons drop out on odd frames, giving a 50% press cadence.
  assign src_eff = src & ~(turbo_mask & {BTN_W{frame_cnt_q[0]}});
`else
  assign src_eff = src;
`endif

  assign cap_vec  = FRAME_W'(src_eff);
  assign sh_next  = shreg >> 1;
  assign idx_next = idx + 1'b1;

  // Synchronise console clock/latch and keep one-cycle history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync   <= '1;
      latch_sync <= '0;
      clk_q      <= 1'b1;
      latch_q    <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        clk_sync[i]   <= clk_sync[i-1];
        latch_sync[i] <= latch_sync[i-1];
      end
      clk_sync[0]   <= bus.snes_clk;
      latch_sync[0] <= bus.snes_latch;
      clk_q         <= clk_sync[SYNC_STAGES-1];
      latch_q       <= latch_sync[SYNC_STAGES-1];
    end
  end

  assign clk_rise   =  clk_sync[SYNC_STAGES-1]   & ~clk_q;
  assign latch_rise =  latch_sync[SYNC_STAGES-1] & ~latch_q;
  assign latch_fall = ~latch_sync[SYNC_STAGES-1] &  latch_q;

  // Frame FSM: latch capture, shift on console clock, padding, timeout; latch edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      idx         <= '0;
      tmo         <= '0;
      snes_out_q  <= SNES_IDLE_LVL;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else if (latch_rise) begin
      // Capture (or restart) from any state; the console re-reads from bit 0.
      state      <= ST_LATCH;
      shreg      <= cap_vec;
      idx        <= '0;
      tmo        <= '0;
      busy_q     <= 1'b1;
      snes_out_q <= ~cap_vec[0];
    end else begin
      case (state)
        ST_IDLE: begin
          snes_out_q <= SNES_IDLE_LVL;
          busy_q     <= 1'b0;
        end
        ST_LATCH: begin
          if (latch_fall) begin
            state <= ST_SHIFT;
            idx   <= '0;
            tmo   <= '0;
          end
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            tmo <= '0;
            if (idx_next == IDX_W'(FRAME_W)) begin
              state       <= ST_IDLE;
              shreg       <= '0;
              idx         <= '0;
              snes_out_q  <= SNES_IDLE_LVL;
              busy_q      <= 1'b0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              shreg      <= sh_next;
              idx        <= idx_next;
              snes_out_q <= ~sh_next[0];
            end
          end else if (tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            // Console stopped clocking; abandon without counting the frame.
            state      <= ST_IDLE;
            shreg      <= '0;
            idx        <= '0;
            tmo        <= '0;
            snes_out_q <= SNES_IDLE_LVL;
            busy_q     <= 1'b0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          snes_out_q <= SNES_IDLE_LVL;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.snes_out  = snes_out_q;
  assign bus.busy      = busy_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_snes_multi_encoder.sv
// Scoreboard bench for snes_multi_encoder: the console-side stimulus pushes the
// expected wire state into a queue and raises a probe; a monitor pops and compares.
module tb_snes_multi_encoder;
  import snes_pkg::*;

  localparam int NUM_CH      = 3;
  localparam int BTN_W       = 8;
  localparam int TIMEOUT_CYC = 4096;
  localparam int HALF        = 8;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH*BTN_W-1:0] ch_data;
  logic [1:0]              sel;
  logic [1:0]              mode;
`ifdef SNES_TURBO_EN
  logic [BTN_W-1:0]        turbo_mask;
`endif
  logic                    probe;

  snes_multi_encoder_if bus ();

  snes_multi_encoder #(
    .NUM_CH      (NUM_CH),
    .BTN_W       (BTN_W),
    .FRAME_W     (16),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef SNES_TURBO_EN
    .turbo_mask (turbo_mask),
`endif
    .ch_data    (ch_data),
    .sel        (sel),
    .mode       (mode),
    .bus        (bus)
  );

  typedef struct {
    logic        out;
    logic        busy;
    logic [15:0] fc;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          chk_id   = 0;
  logic [15:0] exp_fc   = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input int id, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s #%0d got=%0h expected=%0h", name, id, got, want);
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation whenever probed.
  always @(negedge clk) begin
    if (probe) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty got=0 expected=1");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        cmp("snes_out",  e.id, {15'd0, bus.snes_out}, {15'd0, e.out});
        cmp("busy",      e.id, {15'd0, bus.busy},     {15'd0, e.busy});
        cmp("frame_cnt", e.id, bus.frame_cnt,         e.fc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input logic o, input logic b, input logic [15:0] f);
    exp_t e;
    e.out  = o;
    e.busy = b;
    e.fc   = f;
    e.id   = chk_id;
    chk_id++;
    sb_q.push_back(e);
    probe = 1'b1;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic set_ch(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    ch_data = {c2, c1, c0};
  endtask

  // Latch pulse: bit 0 must appear while latched and hold after latch falls.
  task automatic latch_pulse(input logic [15:0] v);
    bus.snes_latch = 1'b1;
    tick(HALF);
    expect_state(~v[0], 1'b1, exp_fc);
    bus.snes_latch = 1'b0;
    tick(HALF);
    expect_state(~v[0], 1'b1, exp_fc);
  endtask

  // n console clocks starting after bit 'start'; checks the next bit or the end of frame.
  task automatic clock_bits(input logic [15:0] v, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      int bi;
      bus.snes_clk = 1'b0;
      tick(HALF);
      bus.snes_clk = 1'b1;
      tick(HALF);
      bi = start + k + 1;
      if (bi < 16) begin
        expect_state(~v[bi], 1'b1, exp_fc);
      end else begin
        exp_fc = exp_fc + 16'd1;
        expect_state(1'b1, 1'b0, exp_fc);
      end
    end
  endtask

  task automatic full_frame(input logic [15:0] v);
    latch_pulse(v);
    clock_bits(v, 0, 16);
  endtask

  initial begin
    probe          = 1'b0;
    reset          = 1'b1;
    bus.snes_clk   = 1'b1;
    bus.snes_latch = 1'b0;
    ch_data        = '0;
    sel            = 2'd0;
    mode           = MODE_FIXED;
`ifdef SNES_TURBO_EN
    turbo_mask     = '0;
`endif
    tick(3);
    expect_state(1'b1, 1'b0, 16'd0);
    reset = 1'b0;
    tick(3);
    expect_state(1'b1, 1'b0, 16'd0);

    // Console clocks while idle are ignored.
    for (int k = 0; k < 3; k++) begin
      bus.snes_clk = 1'b0;
      tick(HALF);
      bus.snes_clk = 1'b1;
      tick(HALF);
    end
    expect_state(1'b1, 1'b0, 16'd0);

    // FIXED sel=1, A5; inputs changed after capture must not affect the frame.
    mode = MODE_FIXED;
    sel  = 2'd1;
    set_ch(8'h00, 8'hA5, 8'h00);
    latch_pulse(16'h00A5);
    set_ch(8'hFF, 8'hFF, 8'hFF);
    sel  = 2'd0;
    mode = MODE_MERGE;
    clock_bits(16'h00A5, 0, 16);

    // MERGE 01|80|10 = 91.
    mode = MODE_MERGE;
    set_ch(8'h01, 8'h80, 8'h10);
    full_frame(16'h0091);

    // FIRST_ACTIVE picks ch1 = 0C; then all zero -> all released.
    mode = MODE_FIRST;
    set_ch(8'h00, 8'h0C, 8'hFF);
    full_frame(16'h000C);
    set_ch(8'h00, 8'h00, 8'h00);
    full_frame(16'h0000);

    // FIXED with sel out of range -> zeros; reserved mode behaves as FIXED.
    mode = MODE_FIXED;
    sel  = 2'd3;
    set_ch(8'hFF, 8'hFF, 8'hFF);
    full_frame(16'h0000);
    mode = MODE_RSVD;
    sel  = 2'd0;
    set_ch(8'h5A, 8'hFF, 8'hFF);
    full_frame(16'h005A);

    // Restart by a new latch mid-shift, with latch and clock rising together.
    mode = MODE_FIXED;
    sel  = 2'd0;
    set_ch(8'hA5, 8'h00, 8'h00);
    latch_pulse(16'h00A5);
    clock_bits(16'h00A5, 0, 3);
    set_ch(8'h3D, 8'h00, 8'h00);
    bus.snes_clk = 1'b0;
    tick(HALF);
    bus.snes_latch = 1'b1;
    bus.snes_clk   = 1'b1;
    tick(HALF);
    expect_state(1'b0, 1'b1, exp_fc);
    bus.snes_latch = 1'b0;
    tick(HALF);
    expect_state(1'b0, 1'b1, exp_fc);
    clock_bits(16'h003D, 0, 16);

    // Timeout: five clocks then silence; frame abandoned, count unchanged.
    set_ch(8'hA5, 8'h00, 8'h00);
    latch_pulse(16'h00A5);
    clock_bits(16'h00A5, 0, 5);
    tick(TIMEOUT_CYC + 20);
    expect_state(1'b1, 1'b0, exp_fc);

    // Reset at bit 7 of a frame, then a clean frame.
    latch_pulse(16'h00A5);
    clock_bits(16'h00A5, 0, 7);
    reset  = 1'b1;
    exp_fc = 16'd0;
    expect_state(1'b1, 1'b0, 16'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    full_frame(16'h00A5);

`ifdef SNES_TURBO_EN
    // Turbo on bit 0: pressed only when frame_cnt is even at capture.
    turbo_mask = 8'h01;
    mode       = MODE_FIXED;
    sel        = 2'd0;
    set_ch(8'h01, 8'h00, 8'h00);
    for (int f = 0; f < 4; f++) begin
      full_frame(exp_fc[0] ? 16'h0000 : 16'h0001);
    end
    turbo_mask = 8'h00;
`endif

    tick(4);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
